// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared types and constants for the VRASED reset controller.
package vrased_pkg;

    localparam int VIOL_W = 6;

    // Bit positions of the monitor strobes within the viol vector
    localparam int V_XSTACK  = 0;
    localparam int V_AC      = 1;
    localparam int V_ATOM    = 2;
    localparam int V_DMA_AC  = 3;
    localparam int V_DMA_DET = 4;
    localparam int V_DMA_XS  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_PC = 2'd2
    } state_t;

endpackage

// File: rtl/vrased_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module vrased_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on request unless already saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Collects VRASED monitor violation strobes into a stretched core reset,
// keeps a sticky cause bitmap and a saturating episode count, and waits
// for the core to fetch from the reset handler before re-arming.
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VIOL_W-1:0] viol,
    input  logic [15:0]       pc,
    input  logic              cause_clr,
    output logic              sys_reset,
    output logic [VIOL_W-1:0] cause,
    output logic              cause_valid,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic              busy
);

    // A single-cycle hold still needs a 1-bit counter
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state, next_state;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              any_v;
    logic              episode;
    logic [VIOL_W-1:0] cause_nxt;

    assign any_v = |viol;

    // Next-state, hold-counter and episode-start decode
    always_comb begin
        next_state = state;
        hold_nxt   = hold;
        episode    = 1'b0;
        case (state)
            IDLE: begin
                if (any_v) begin
                    next_state = ASSERT;
                    hold_nxt   = HOLD_INIT;
                    episode    = 1'b1;
                end
            end
            ASSERT: begin
                // A fresh violation restarts the stretch but is the same episode
                if (any_v)
                    hold_nxt = HOLD_INIT;
                else if (hold == '0)
                    next_state = WAIT_PC;
                else
                    hold_nxt = hold - 1'b1;
            end
            WAIT_PC: begin
                // Violation outranks the handler fetch seen in the same cycle
                if (any_v) begin
                    next_state = ASSERT;
                    hold_nxt   = HOLD_INIT;
                    episode    = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                hold_nxt   = '0;
            end
        endcase
    end

    // Clear drops old bits, but bits arriving in the same cycle survive
    always_comb begin
        cause_nxt = (cause_clr ? '0 : cause) | viol;
    end

    // State, hold counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold        <= '0;
            sys_reset   <= 1'b0;
            cause       <= '0;
            cause_valid <= 1'b0;
        end else begin
            state       <= next_state;
            hold        <= hold_nxt;
            sys_reset   <= (next_state == ASSERT);
            cause       <= cause_nxt;
            cause_valid <= |cause_nxt;
        end
    end

    assign busy = (state != IDLE);

    vrased_sat_counter #(
        .WIDTH (CNT_W)
    ) u_viol_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (episode),
        .count (viol_cnt)
    );

endmodule
